tile_mem_seq: RTL
=================

Name: tile_mem_seq

Overview:
- Parametrised successor to the systolic-array top's fixed 64-beat load/store sequencing.
- Accepts one tile instruction at a time: PRELOADA, TMMA-B, PRELOADC or POSTSTOREC.
- For each instruction it generates strided read or write bursts of programmable length.
- Read bursts are credit-limited by an outstanding-request cap; read data and write data are fully backpressured.
- Sits between the tile-instruction issue stage and the memory port, and feeds the A buffer and shift registers.

Parameters:
ADDR_WIDTH, 64, address width; address arithmetic wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 256, beat width for load and store data
BEAT_W, 6, width of beat-count field; max burst 2^BEAT_W beats
MAX_OUTSTANDING, 8, max AR accepted without matching R (>=1)
OUTS_W, 4, counter width; must satisfy 2^OUTS_W > MAX_OUTSTANDING

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid_i  in  1  instruction offered
inst_ready_o  out  1  sequencer can accept an instruction
inst_type_i  in  2  0=TMMA(B load), 1=PRELOADA, 2=PRELOADC, 3=POSTSTOREC
inst_addr_i  in  ADDR_WIDTH  base address
inst_stride_i  in  ADDR_WIDTH  byte stride added per beat
inst_beats_i  in  BEAT_W  beat count minus one
ar_valid_o  out  1  read request valid
ar_ready_i  in  1  read request accepted
ar_addr_o  out  ADDR_WIDTH  read address
r_valid_i  in  1  read data valid
r_ready_o  out  1  read data accepted
r_data_i  in  DATA_WIDTH  read data
ld_valid_o  out  1  load beat to consumer
ld_ready_i  in  1  consumer accepts beat
ld_type_o  out  2  latched inst type (routes to A buffer / left / top)
ld_cnt_o  out  BEAT_W  index of current load beat
ld_data_o  out  DATA_WIDTH  load beat data
st_valid_i  in  1  array output beat valid
st_ready_o  out  1  array output beat accepted
st_data_i  in  DATA_WIDTH  array output data
aw_valid_o  out  1  write valid
aw_ready_i  in  1  write accepted
aw_addr_o  out  ADDR_WIDTH  write address
aw_data_o  out  DATA_WIDTH  write data
done_o  out  1  one-cycle pulse, instruction complete
busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, LOAD, STORE.
- Reset: state IDLE; all counters, address and type registers 0. Outputs at reset: inst_ready_o=1; all other outputs 0.
- Reset mid-operation aborts the instruction; no done_o is issued.
- inst_ready_o = (state==IDLE).
- Instruction handshake (inst_valid_i & inst_ready_o):
  - latches type, addr, stride and beats;
  - zeroes ar_idx, r_idx and aw_idx;
  - next state is STORE if type==3, otherwise LOAD.
- LOAD, request side:
  - ar_valid_o = (ar_idx <= beats) & (outs < MAX_OUTSTANDING).
  - ar_addr_o = running read address: base initially, +stride on each AR handshake.
- LOAD, data side:
  - ld_valid_o = r_valid_i; r_ready_o = ld_ready_i.
  - ld_data_o = r_data_i combinationally; ld_cnt_o = r_idx; ld_type_o = latched type.
  - r_idx increments on each R handshake.
- Outstanding counter outs:
  - +1 on AR handshake, -1 on R handshake; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- r_ready_o=0 in IDLE and STORE; an R beat arriving outside LOAD is a protocol error.
- STORE:
  - aw_valid_o = st_valid_i; st_ready_o = aw_ready_i; aw_data_o = st_data_i.
  - aw_addr_o = running write address: base initially, +stride per AW handshake.
  - ld_valid_o=0 and ar_valid_o=0 in STORE.
- Completion:
  - LOAD completes on the R handshake with r_idx==beats.
  - STORE completes on the AW handshake with aw_idx==beats.
  - At the completion edge: state←IDLE and done_o←1 for exactly one cycle. A new instruction may be accepted in that done cycle.
- Width rules:
  - Indices are BEAT_W bits; beats=2^BEAT_W-1 gives a full burst.
  - ar_idx is BEAT_W+1 bits so it does not wrap before the request side ends.
  - Address additions are truncated to ADDR_WIDTH (wrap permitted).
- Latency: first AR is visible the cycle after instruction acceptance. Load and store data paths are zero-latency pass-through.

Decomposition:
- Shared package (tinst_pkg), defining:
  - TINST_TYPE_* encodings;
  - TINST_TYPE_WIDTH=2;
  - state encoding for IDLE/LOAD/STORE;
  - default ADDR_WIDTH / DATA_WIDTH.
- One sub-module: tile_addr_gen. It is a base/stride running-address register with load, step and index outputs, and is instantiated twice (read side and write side).

Test Plan:
- PRELOADA, addr=0x1000, stride=0x100, beats=3, ar_ready=1, r_valid every cycle:
  - ar_addr = 0x1000, 0x1100, 0x1200, 0x1300;
  - ld_cnt = 0..3;
  - done_o pulses once, the cycle after the 4th R handshake;
  - inst_ready_o returns to 1.
- TMMA, beats=15, MAX_OUTSTANDING=8, r_valid held low for 20 cycles:
  - exactly 8 AR handshakes, then ar_valid_o=0;
  - after 4 R beats, 4 more ARs issue;
  - total ARs = 16.
- ld_ready_i toggled 1010... during PRELOADC beats=7:
  - r_ready_o mirrors ld_ready_i;
  - ld_data_o order is unchanged;
  - done_o only after beat 7.
- POSTSTOREC, addr=0xFFFF_FFFF_FFFF_FF00, stride=0x100, beats=1:
  - aw_addr = 0x...FF00 then 0x0 (wrap);
  - st_ready_o follows aw_ready_i;
  - done_o after the 2nd AW handshake.
- Back-to-back: second inst_valid_i held high through the first instruction's done_o cycle:
  - second instruction accepted on the done cycle with no idle gap;
  - counters restart at 0.
- rst_n asserted during LOAD with outs=5:
  - all outputs 0 except inst_ready_o=1;
  - no done_o;
  - next instruction runs normally.

Source files
------------

// File: rtl/tinst_pkg.sv
// Shared definitions for the tile-instruction memory sequencer: instruction
// encodings, FSM state encoding and default bus widths.
package tinst_pkg;

  localparam int TINST_TYPE_WIDTH   = 2;
  localparam int DEFAULT_ADDR_WIDTH = 64;
  localparam int DEFAULT_DATA_WIDTH = 256;

  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA       = 2'd0;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA   = 2'd1;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC   = 2'd2;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_POSTSTOREC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } seq_state_e;

  function automatic logic tinst_is_store(input logic [TINST_TYPE_WIDTH-1:0] t);
    return (t == TINST_TYPE_POSTSTOREC);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Running base/stride address register with a beat index; load restarts the
// walk at base, each step advances the address by stride (wrapping).
module tile_addr_gen #(
  parameter int ADDR_WIDTH = 64,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [IDX_W-1:0]      idx_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [IDX_W-1:0]      idx_q;

  // Address, stride and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      stride_q <= stride_i;
      idx_q    <= '0;
    end else if (step_i) begin
      addr_q   <= addr_q + stride_q;
      idx_q    <= idx_q + IDX_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/tile_mem_seq.sv
// Tile-instruction memory sequencer: turns one load/store tile instruction
// into a strided, credit-limited read burst or a backpressured write burst.
module tile_mem_seq
  import tinst_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int BEAT_W          = 6,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUTS_W          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inst_valid_i,
  output logic                        inst_ready_o,
  input  logic [TINST_TYPE_WIDTH-1:0] inst_type_i,
  input  logic [ADDR_WIDTH-1:0]       inst_addr_i,
  input  logic [ADDR_WIDTH-1:0]       inst_stride_i,
  input  logic [BEAT_W-1:0]           inst_beats_i,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [ADDR_WIDTH-1:0]       ar_addr_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [DATA_WIDTH-1:0]       r_data_i,
  output logic                        ld_valid_o,
  input  logic                        ld_ready_i,
  output logic [TINST_TYPE_WIDTH-1:0] ld_type_o,
  output logic [BEAT_W-1:0]           ld_cnt_o,
  output logic [DATA_WIDTH-1:0]       ld_data_o,
  input  logic                        st_valid_i,
  output logic                        st_ready_o,
  input  logic [DATA_WIDTH-1:0]       st_data_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [ADDR_WIDTH-1:0]       aw_addr_o,
  output logic [DATA_WIDTH-1:0]       aw_data_o,
  output logic                        done_o,
  output logic                        busy_o
);

  seq_state_e                  state_q, state_d;
  logic                        done_q, done_d;
  logic [TINST_TYPE_WIDTH-1:0] type_q;
  logic [BEAT_W-1:0]           beats_q;
  logic [BEAT_W-1:0]           r_idx_q;
  logic [OUTS_W-1:0]           outs_q;

  logic              is_load_s, is_store_s;
  logic              inst_hs_s, ar_hs_s, r_hs_s, aw_hs_s;
  logic              ld_last_s, st_last_s;
  logic [BEAT_W:0]   ar_idx_s, aw_idx_s;
  logic [ADDR_WIDTH-1:0] ar_addr_s, aw_addr_s;

  assign is_load_s  = (state_q == ST_LOAD);
  assign is_store_s = (state_q == ST_STORE);

  assign inst_ready_o = (state_q == ST_IDLE);
  assign busy_o       = ~inst_ready_o;
  assign done_o       = done_q;

  // ar_idx carries one extra bit so a full 2^BEAT_W burst can still stop
  assign ar_valid_o = is_load_s & (ar_idx_s <= {1'b0, beats_q})
                    & (outs_q < OUTS_W'(MAX_OUTSTANDING));
  assign ar_addr_o  = ar_addr_s;
  assign r_ready_o  = is_load_s & ld_ready_i;
  assign ld_valid_o = is_load_s & r_valid_i;
  assign ld_data_o  = is_load_s ? r_data_i : '0;
  assign ld_cnt_o   = r_idx_q;
  assign ld_type_o  = type_q;

  assign aw_valid_o = is_store_s & st_valid_i;
  assign st_ready_o = is_store_s & aw_ready_i;
  assign aw_data_o  = is_store_s ? st_data_i : '0;
  assign aw_addr_o  = aw_addr_s;

  assign inst_hs_s = inst_valid_i & inst_ready_o;
  assign ar_hs_s   = ar_valid_o & ar_ready_i;
  assign r_hs_s    = r_valid_i & r_ready_o;
  assign aw_hs_s   = aw_valid_o & aw_ready_i;
  assign ld_last_s = r_hs_s & (r_idx_q == beats_q);
  assign st_last_s = aw_hs_s & (aw_idx_s == {1'b0, beats_q});

  tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(BEAT_W + 1)) u_rd_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (inst_hs_s),
    .step_i  (ar_hs_s),
    .base_i  (inst_addr_i),
    .stride_i(inst_stride_i),
    .addr_o  (ar_addr_s),
    .idx_o   (ar_idx_s)
  );

  tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(BEAT_W + 1)) u_wr_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (inst_hs_s),
    .step_i  (aw_hs_s),
    .base_i  (inst_addr_i),
    .stride_i(inst_stride_i),
    .addr_o  (aw_addr_s),
    .idx_o   (aw_idx_s)
  );

  // Next-state and completion pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid_i) begin
          state_d = tinst_is_store(inst_type_i) ? ST_STORE : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld_last_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_STORE: begin
        if (st_last_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STORE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Latched instruction fields, load-beat index and outstanding-read credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q  <= '0;
      beats_q <= '0;
      r_idx_q <= '0;
      outs_q  <= '0;
    end else if (inst_hs_s) begin
      type_q  <= inst_type_i;
      beats_q <= inst_beats_i;
      r_idx_q <= '0;
      outs_q  <= '0;
    end else begin
      if (r_hs_s) begin
        r_idx_q <= r_idx_q + BEAT_W'(1);
      end
      case ({ar_hs_s, r_hs_s})
        2'b10:   outs_q <= outs_q + OUTS_W'(1);
        2'b01:   outs_q <= outs_q - OUTS_W'(1);
        default: outs_q <= outs_q;
      endcase
    end
  end

endmodule
